// File: rtl/mio_ram_arbiter_if.sv
// Bus bundle between two masters, the arbiter and the single mio_ram data port.
// The arbiter uses the slave view; the master view holds the masters and the RAM.
interface mio_ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic [1:0]    grant;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output ram_a, ram_wdata, ram_we,
    input  ram_rdata,
    output grant, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  ram_a, ram_wdata, ram_we,
    output ram_rdata,
    input  grant, busy
  );
endinterface

// File: rtl/mio_ram_arbiter.sv
// Two-master arbiter for the mio_ram data port: one transaction at a time,
// sequenced IDLE -> ISSUE -> (WAIT) -> ACK, with round-robin or fixed priority.
module mio_ram_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int FAIR   = 1
) (
  input logic              clk,
  input logic              clrn,
  mio_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [2:0] LatLoad = 3'(RD_LAT);
  localparam bit         FairRr  = (FAIR != 0);

  state_t        state;
  state_t        state_nxt;
  logic          any_req;
  logic          pick1;

  logic          owner_p0;
  logic          last_p0;
  logic          we_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;
  logic [2:0]    cnt_p0;
  logic [DW-1:0] rdata0_p1;
  logic [DW-1:0] rdata1_p1;

  assign any_req = bus.m0_req | bus.m1_req;
  // On a tie, round-robin hands the slot to whichever master did not win last.
  assign pick1   = bus.m1_req & (~bus.m0_req | (FairRr & ~last_p0));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_p0 ? ACK : WAIT;
      WAIT:    if (cnt_p0 == 3'd1) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: winner's request latched at the grant edge; stage p1: read return.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      owner_p0  <= 1'b0;
      last_p0   <= 1'b1;
      we_p0     <= 1'b0;
      addr_p0   <= '0;
      wdata_p0  <= '0;
      cnt_p0    <= '0;
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_p0 <= pick1;
            last_p0  <= pick1;
            we_p0    <= pick1 ? bus.m1_we    : bus.m0_we;
            addr_p0  <= pick1 ? bus.m1_addr  : bus.m0_addr;
            wdata_p0 <= pick1 ? bus.m1_wdata : bus.m0_wdata;
          end
        end
        ISSUE: begin
          if (!we_p0) cnt_p0 <= LatLoad;
        end
        WAIT: begin
          cnt_p0 <= cnt_p0 - 3'd1;
          if (cnt_p0 == 3'd1) begin
            if (owner_p0) rdata1_p1 <= bus.ram_rdata;
            else          rdata0_p1 <= bus.ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ram_a     = '0;
    bus.ram_wdata = '0;
    bus.ram_we    = 1'b0;
    bus.m0_ack    = 1'b0;
    bus.m1_ack    = 1'b0;
    bus.busy      = (state != IDLE);
    bus.grant     = 2'b00;
    if (state != IDLE) bus.grant = owner_p0 ? 2'b10 : 2'b01;
    case (state)
      ISSUE: begin
        bus.ram_a     = addr_p0;
        bus.ram_wdata = wdata_p0;
        bus.ram_we    = we_p0;
      end
      WAIT: begin
        bus.ram_a     = addr_p0;
        bus.ram_wdata = wdata_p0;
      end
      ACK: begin
        bus.m0_ack = ~owner_p0;
        bus.m1_ack = owner_p0;
      end
      default: ;
    endcase
  end

  assign bus.m0_rdata = rdata0_p1;
  assign bus.m1_rdata = rdata1_p1;

endmodule

// File: doc/mio_ram_arbiter.md
Name: mio_ram_arbiter

Overview:
Two-master arbiter for the single data port of mio_ram. Master 0 is the CPU data path from mio_bus; master 1 is a secondary bus master such as a DMA or loader. The block accepts level requests, grants one master per transaction (round-robin or fixed priority) and sequences the RAM port through issue and read-wait. It returns read data with a one-cycle ack pulse to the granted master.

Parameters:
AW, 32, address width
DW, 32, data width
RD_LAT, 1, RAM read latency in cycles from address to ram_rdata valid; legal range 1..4
FAIR, 1, 1 = round-robin between masters; 0 = fixed priority, master 0 always wins

Ports:
clk  in  1  system clock; all state on rising edge
clrn  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request, level
m0_we  in  1  master 0 write enable (1 = write)
m0_addr  in  AW  master 0 word address
m0_wdata  in  DW  master 0 write data
m0_rdata  out  DW  master 0 read data, registered
m0_ack  out  1  master 0 transaction done, 1-cycle pulse
m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  -  same as m0, for master 1
ram_a  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_we  out  1  RAM write strobe
ram_rdata  in  DW  RAM read data
grant  out  2  one-hot current owner; 00 when idle
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset, asynchronous on clrn=0:
  - FSM goes to IDLE; all outputs are 0.
  - Internal last-grant pointer is set to 1, so master 0 wins the first tie.
  - The internal latched addr/we/wdata and the wait counter are cleared.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise select a winner:
    - Only one master requesting: that master wins.
    - Both requesting with FAIR=1: the master not equal to last-grant wins.
    - Both requesting with FAIR=0: master 0 wins.
  - On the clock edge, latch the winner's addr/we/wdata, set grant, update last-grant, and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive ram_a and ram_wdata from the latched values; ram_we = latched we.
  - If write, go to ACK. If read, load the counter with RD_LAT and go to WAIT.
- WAIT:
  - ram_a is held and ram_we = 0. Decrement the counter each cycle.
  - In the cycle where the counter reaches 1, capture ram_rdata into the granted master's rdata register at the edge, then go to ACK.
- ACK (1 cycle):
  - Assert ack of the granted master only; grant is still valid. Return to IDLE.
- Latency, req sampled in IDLE at cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT.
  - At least one IDLE cycle separates transactions.
- Data stability:
  - mN_rdata is valid from the ack cycle and holds until that master's next read completes.
  - Writes leave mN_rdata unchanged.
- ram_a and ram_wdata are 0 in IDLE. ram_we is high only in ISSUE of a write.
- Master inputs are ignored after latching. Changes to addr/wdata/we during ISSUE, WAIT or ACK have no effect.
- Request withdrawal:
  - Dropping req after the grant edge does not abort; the transaction completes and ack still pulses.
  - Dropping req before the grant edge means no transaction.
- A req still high in the IDLE cycle after ack is a new transaction. Masters deassert req in the cycle after ack for single accesses.
- FAIR=1 with both masters holding req: grants alternate 0,1,0,1...
- FAIR=0 with master 0 holding req continuously: master 1 starves. This is intended.
- Reset during ISSUE with ram_we=1: ram_we drops immediately (asynchronous); no ack is issued.

Test Plan:
1. Reset, then m0 write addr=0x10 data=0xDEADBEEF: ram_we=1 in cycle 1 only with ram_a=0x10; m0_ack in cycle 2; grant=01 during cycles 1-2. Then m0 read 0x10 with RD_LAT=1 and a RAM model: m0_ack in cycle 3; m0_rdata=0xDEADBEEF.
2. m0_req and m1_req rise together and stay high, FAIR=1: grant sequence is 01,10,01,10; each ack goes to the matching master; IDLE between transactions.
3. Same stimulus with FAIR=0: only m0 is granted over 4 transactions; m1_ack stays 0.
4. m1 read, RD_LAT=3, m1_addr changed to 0x99 during WAIT: ram_a holds the original address; m1_ack at cycle 5; m1_rdata equals the RAM content at the original address.
5. Pulse clrn low during ISSUE of an m0 write: ram_we, grant, busy and acks drop to 0 immediately. After release, the first tie goes to m0.
6. m0 deasserts req in the ISSUE cycle of a read: transaction completes, m0_ack pulses once, no second transaction starts.
